// File: rtl/cpu_pkg.sv
// Shared opcode, ALU and sequencer definitions for the 8-bit accumulator CPU.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_JNZ = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_PASS_B = 4'd5;

    typedef enum logic [2:0] {
        IDLE,
        F0,
        F1,
        A0,
        A1,
        EX,
        M0,
        HALT
    } state_t;

    typedef enum logic [1:0] {
        JC_ALWAYS,
        JC_Z,
        JC_NZ
    } jcond_t;

endpackage

// File: rtl/cpu_decode.sv
// Combinational opcode classifier: maps ir[7:4] to the sequencer's control hints.
module cpu_decode
    import cpu_pkg::*;
(
    input  logic [3:0] i_opcode,
    output logic       o_needs_arg,
    output logic       o_is_mem_read,
    output logic       o_is_store,
    output logic       o_is_jump,
    output jcond_t     o_jump_cond,
    output logic [3:0] o_alu_op,
    output logic       o_is_illegal
);

    always_comb begin
        o_needs_arg   = 1'b0;
        o_is_mem_read = 1'b0;
        o_is_store    = 1'b0;
        o_is_jump     = 1'b0;
        o_jump_cond   = JC_ALWAYS;
        o_alu_op      = ALU_ADD;
        o_is_illegal  = 1'b0;
        case (i_opcode)
            OP_NOP, OP_HLT: ;
            OP_LDA: begin
                o_needs_arg   = 1'b1;
                o_is_mem_read = 1'b1;
                o_alu_op      = ALU_PASS_B;
            end
            OP_STA: begin
                o_needs_arg = 1'b1;
                o_is_store  = 1'b1;
            end
            OP_ADD: begin
                o_needs_arg   = 1'b1;
                o_is_mem_read = 1'b1;
                o_alu_op      = ALU_ADD;
            end
            OP_SUB: begin
                o_needs_arg   = 1'b1;
                o_is_mem_read = 1'b1;
                o_alu_op      = ALU_SUB;
            end
            OP_AND: begin
                o_needs_arg   = 1'b1;
                o_is_mem_read = 1'b1;
                o_alu_op      = ALU_AND;
            end
            OP_OR: begin
                o_needs_arg   = 1'b1;
                o_is_mem_read = 1'b1;
                o_alu_op      = ALU_OR;
            end
            OP_XOR: begin
                o_needs_arg   = 1'b1;
                o_is_mem_read = 1'b1;
                o_alu_op      = ALU_XOR;
            end
            OP_LDI: begin
                o_needs_arg = 1'b1;
                o_alu_op    = ALU_PASS_B;
            end
            OP_JMP: begin
                o_needs_arg = 1'b1;
                o_is_jump   = 1'b1;
                o_jump_cond = JC_ALWAYS;
            end
            OP_JZ: begin
                o_needs_arg = 1'b1;
                o_is_jump   = 1'b1;
                o_jump_cond = JC_Z;
            end
            OP_JNZ: begin
                o_needs_arg = 1'b1;
                o_is_jump   = 1'b1;
                o_jump_cond = JC_NZ;
            end
            default: o_is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_control.sv
// Fetch/decode/execute sequencer for the accumulator CPU; drives PC, memory,
// ALU and accumulator controls as Moore outputs of state and opcode.
//
// state | meaning
// IDLE  | waiting for run
// F0    | present PC as opcode address
// F1    | capture opcode, step PC, dispatch
// A0    | present PC as operand address
// A1    | capture operand, step PC
// EX    | execute LDI/JMP/Jcc/STA, or issue operand read
// M0    | apply memory operand through the ALU into the accumulator
// HALT  | stopped until reset
module cpu_control
    import cpu_pkg::*;
#(
    parameter int DATA_W          = 8,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [DATA_W-1:0] pc_value,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              alu_zero,
    output logic              pc_inc,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_next,
    output logic [DATA_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [3:0]        alu_op,
    output logic [DATA_W-1:0] alu_b,
    output logic              acc_load,
    output logic              halted,
    output logic              illegal,
    output logic              busy
);

    state_t            r_state;
    state_t            w_next_state;
    logic [3:0]        r_ir;
    logic [DATA_W-1:0] r_arg;
    logic              r_z;
    logic              r_illegal;

    logic       w_ir_load;
    logic       w_arg_load;
    logic       w_z_load;
    logic       w_set_illegal;
    logic [3:0] w_opcode;
    logic       w_needs_arg;
    logic       w_is_mem_read;
    logic       w_is_store;
    logic       w_is_jump;
    jcond_t     w_jump_cond;
    logic [3:0] w_alu_op;
    logic       w_is_illegal;
    logic       w_take;

    // In F1 the opcode is still on the read bus; afterwards it lives in r_ir.
    assign w_opcode = (r_state == F1) ? mem_rdata[DATA_W-1 -: 4] : r_ir;

    cpu_decode u_decode (
        .i_opcode      (w_opcode),
        .o_needs_arg   (w_needs_arg),
        .o_is_mem_read (w_is_mem_read),
        .o_is_store    (w_is_store),
        .o_is_jump     (w_is_jump),
        .o_jump_cond   (w_jump_cond),
        .o_alu_op      (w_alu_op),
        .o_is_illegal  (w_is_illegal)
    );

    assign w_take = (w_jump_cond == JC_ALWAYS) |
                    ((w_jump_cond == JC_Z)  &  r_z) |
                    ((w_jump_cond == JC_NZ) & ~r_z);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_ir      <= '0;
            r_arg     <= '0;
            r_z       <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_ir_load)     r_ir      <= mem_rdata[DATA_W-1 -: 4];
            if (w_arg_load)    r_arg     <= mem_rdata;
            if (w_z_load)      r_z       <= alu_zero;
            if (w_set_illegal) r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_ir_load     = 1'b0;
        w_arg_load    = 1'b0;
        w_z_load      = 1'b0;
        w_set_illegal = 1'b0;
        pc_inc        = 1'b0;
        pc_load       = 1'b0;
        pc_next       = '0;
        mem_addr      = '0;
        mem_we        = 1'b0;
        alu_op        = 4'd0;
        alu_b         = '0;
        acc_load      = 1'b0;
        halted        = 1'b0;
        busy          = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (run) w_next_state = F0;
            end
            F0: begin
                mem_addr     = pc_value;
                w_next_state = F1;
            end
            F1: begin
                pc_inc    = 1'b1;
                w_ir_load = 1'b1;
                if (w_is_illegal) begin
                    w_set_illegal = 1'b1;
                    w_next_state  = HALT_ON_ILLEGAL ? HALT : F0;
                end else if (w_needs_arg) begin
                    w_next_state = A0;
                end else if (w_opcode == OP_HLT) begin
                    w_next_state = HALT;
                end else begin
                    w_next_state = F0;
                end
            end
            A0: begin
                mem_addr     = pc_value;
                w_next_state = A1;
            end
            A1: begin
                pc_inc       = 1'b1;
                w_arg_load   = 1'b1;
                w_next_state = EX;
            end
            EX: begin
                w_next_state = F0;
                if (w_is_jump) begin
                    pc_next = r_arg;
                    pc_load = w_take;
                end else if (w_is_store) begin
                    mem_addr = r_arg;
                    mem_we   = 1'b1;
                end else if (w_is_mem_read) begin
                    mem_addr     = r_arg;
                    w_next_state = M0;
                end else begin
                    // Only LDI reaches EX without a jump, store or memory read.
                    alu_op   = ALU_PASS_B;
                    alu_b    = r_arg;
                    acc_load = 1'b1;
                    w_z_load = 1'b1;
                end
            end
            M0: begin
                alu_op       = w_alu_op;
                alu_b        = mem_rdata;
                acc_load     = 1'b1;
                w_z_load     = 1'b1;
                w_next_state = F0;
            end
            HALT: begin
                halted = 1'b1;
                busy   = 1'b0;
            end
            default: begin
                busy         = 1'b0;
                w_next_state = IDLE;
            end
        endcase
    end

    assign illegal = r_illegal;

endmodule

// File: doc/cpu_control.md
Name: cpu_control

Overview:
Fetch/decode/execute sequencer for the 8-bit accumulator CPU. It is the initiator side of the datapath interface and drives these controls:
- program counter load/increment
- memory address and write enable
- ALU op and B operand
- accumulator load

It consumes memory read data, the current PC and the ALU zero flag. It sits beside the datapath inside cpu and owns all instruction sequencing.

Parameters:
DATA_W, 8, datapath and memory word width; also the address width.
HALT_ON_ILLEGAL, 1, 1: an illegal opcode halts; 0: it executes as NOP and sets the sticky illegal flag.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; all state and outputs cleared
run  in  1  start pulse, sampled only in IDLE
pc_value  in  DATA_W  current PC from the PC register
mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_addr is presented
alu_zero  in  1  ALU zero flag for the current alu_op/alu_b
pc_inc  out  1  increment PC this cycle
pc_load  out  1  load pc_next into PC this cycle
pc_next  out  DATA_W  jump target
mem_addr  out  DATA_W  memory address
mem_we  out  1  memory write strobe; datapath routes the accumulator to memory data_in
alu_op  out  4  ALU operation code
alu_b  out  DATA_W  ALU B operand
acc_load  out  1  accumulator captures the ALU result this cycle
halted  out  1  in HALT state
illegal  out  1  sticky; set on undefined opcode
busy  out  1  not IDLE and not HALT

Behaviour:
- Reset (async, immediate): state = IDLE. Outputs 0: pc_inc, pc_load, pc_next, mem_addr, mem_we, alu_op, alu_b, acc_load, halted, illegal, busy. Internal ir, arg and z are 0. Reset mid-instruction aborts it with no partial strobe.
- Instruction format: byte 0 is the opcode in [7:4], with [3:0] ignored. Operand-bearing opcodes take byte 1 as the address or immediate.
- Opcodes:
  - 0 NOP
  - 1 LDA a
  - 2 STA a
  - 3 ADD a
  - 4 SUB a
  - 5 AND a
  - 6 OR a
  - 7 XOR a
  - 8 LDI imm
  - 9 JMP a
  - A JZ a
  - B JNZ a
  - F HLT
  - C, D, E are illegal.
- Strobe rule: all control outputs are Moore/decoded from state+ir, and every strobe is a single-cycle pulse.
- States:
  - IDLE: run=1 -> F0.
  - F0: mem_addr=pc_value -> F1.
  - F1: ir<=mem_rdata; pc_inc=1.
    - NOP -> F0.
    - HLT -> HALT.
    - Illegal: illegal<=1, then -> HALT if HALT_ON_ILLEGAL, else F0.
    - Otherwise -> A0.
  - A0: mem_addr=pc_value (already incremented) -> A1.
  - A1: arg<=mem_rdata; pc_inc=1 -> EX.
  - EX, by opcode, then -> F0 unless noted:
    - LDI: alu_op=PASS_B, alu_b=arg, acc_load=1, z<=alu_zero.
    - JMP: pc_load=1, pc_next=arg.
    - JZ: pc_load=z. JNZ: pc_load=!z. pc_next=arg in both.
    - STA: mem_addr=arg, mem_we=1.
    - LDA/ADD/SUB/AND/OR/XOR: mem_addr=arg -> M0.
  - M0: alu_b=mem_rdata; alu_op mapped (LDA->PASS_B); acc_load=1; z<=alu_zero -> F0.
  - HALT: halted=1; exited only by reset; run ignored.
- Latency in cycles: NOP 2; LDI, JMP, Jcc and STA 5; LDA and the ALU ops 6.
- z updates only on acc_load. Jcc tests z as registered at the previous acc_load.
- pc_inc and pc_load are never asserted together.
- PC wrap-around 0xFF->0x00 is the PC register's concern. Operand fetch at 0xFF reads byte 0x00.
- run asserted while busy has no effect.

Decomposition:
- cpu_pkg:
  - opcode localparams (OP_NOP..OP_HLT)
  - ALU op codes (ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_XOR=4, ALU_PASS_B=5)
  - state enum (IDLE, F0, F1, A0, A1, EX, M0, HALT)
- One combinational sub-module, cpu_decode: ir[7:4] -> needs_arg, is_mem_read, is_store, is_jump, jump_cond, alu_op, is_illegal.
- The FSM and registers stay in cpu_control.

Test Plan:
1. Assert reset with run=1 held -> all outputs 0 while reset is high. Release, pulse run with pc_value=0x00 -> next cycle mem_addr=0x00, busy=1.
2. Program 0x80,0x05,0x20,0x80,0xF0 (LDI 5; STA 0x80; HLT) -> expect:
   - one acc_load with alu_op=5, alu_b=0x05
   - one mem_we with mem_addr=0x80
   - five pc_inc pulses in total
   - then halted=1 stable for 20 cycles
3. LDI 0x00 then JZ 0x10 -> pc_load=1 with pc_next=0x10. Repeat with LDI 0x01 -> no pc_load; JNZ is the converse.
4. mem[0x40]=0x03, instruction ADD 0x40 -> mem_addr=0x40 in EX. Next cycle alu_op=0, alu_b=0x03, acc_load=1. Instruction total 6 cycles.
5. Opcode byte 0xC0 -> illegal=1 and halted=1. With HALT_ON_ILLEGAL=0 -> illegal=1, fetch continues at the next byte.
6. Assert reset asynchronously in M0 mid-cycle -> acc_load/busy drop before the next clk edge. State IDLE; illegal and z cleared.
